// File: rtl/alu_ops_pkg.sv
`default_nettype none
//==============================================================================
// alu_ops_pkg : opcodes, PSR layout and per-opcode flag write masks
// Rev 1.0
//==============================================================================
package alu_ops_pkg;

  localparam int OPC_W = 8;
  localparam int PSR_W = 5;

  localparam int PSR_C = 4;
  localparam int PSR_F = 3;
  localparam int PSR_L = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  localparam logic [OPC_W-1:0] OP_NOP   = 8'h00;
  localparam logic [OPC_W-1:0] OP_ADD   = 8'h01;
  localparam logic [OPC_W-1:0] OP_ADDI  = 8'h02;
  localparam logic [OPC_W-1:0] OP_ADDU  = 8'h03;
  localparam logic [OPC_W-1:0] OP_ADDUI = 8'h04;
  localparam logic [OPC_W-1:0] OP_ADDC  = 8'h05;
  localparam logic [OPC_W-1:0] OP_ADDCI = 8'h06;
  localparam logic [OPC_W-1:0] OP_SUB   = 8'h07;
  localparam logic [OPC_W-1:0] OP_SUBI  = 8'h08;
  localparam logic [OPC_W-1:0] OP_CMP   = 8'h09;
  localparam logic [OPC_W-1:0] OP_CMPI  = 8'h0A;
  localparam logic [OPC_W-1:0] OP_AND   = 8'h0B;
  localparam logic [OPC_W-1:0] OP_OR    = 8'h0C;
  localparam logic [OPC_W-1:0] OP_XOR   = 8'h0D;
  localparam logic [OPC_W-1:0] OP_NOT   = 8'h0E;
  localparam logic [OPC_W-1:0] OP_TEST  = 8'h0F;
  localparam logic [OPC_W-1:0] OP_LSH   = 8'h10;
  localparam logic [OPC_W-1:0] OP_RSH   = 8'h11;
  localparam logic [OPC_W-1:0] OP_ARSH  = 8'h12;
  localparam logic [OPC_W-1:0] OP_MUL   = 8'h13;
  localparam logic [OPC_W-1:0] OP_MULU  = 8'h14;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_MULU);
  endfunction

  function automatic logic op_is_mul(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULU);
  endfunction

  // Mask bit order matches the PSR: {C,F,L,N,Z}
  function automatic logic [PSR_W-1:0] flag_mask(input logic [OPC_W-1:0] op);
    logic [PSR_W-1:0] m;
    m = 5'b00000;
    case (op)
      OP_ADD,  OP_ADDI,
      OP_SUB,  OP_SUBI:  m = 5'b11011;
      OP_ADDU, OP_ADDUI,
      OP_ADDC, OP_ADDCI: m = 5'b10011;
      OP_CMP,  OP_CMPI:  m = 5'b00111;
      OP_AND,  OP_OR, OP_XOR, OP_NOT, OP_TEST,
      OP_LSH,  OP_RSH, OP_ARSH, OP_MUL: m = 5'b00011;
      OP_MULU:           m = 5'b00001;
      default:           m = 5'b00000;
    endcase
    return m;
  endfunction

  function automatic logic [PSR_W-1:0] psr_merge(input logic [PSR_W-1:0] old_psr,
                                                 input logic [PSR_W-1:0] flags,
                                                 input logic [PSR_W-1:0] mask);
    return (old_psr & ~mask) | (flags & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_psr_if.sv
`default_nettype none
//==============================================================================
// alu_seq_psr_if : operand handshake and result bus of the sequential ALU
// Rev 1.0
//==============================================================================
interface alu_seq_psr_if
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             psr_we;
  logic [PSR_W-1:0] psr_wdata;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [PSR_W-1:0] psr;
  logic             illegal_op;

  modport master (
    output in_valid, opcode, a, b, psr_we, psr_wdata,
    input  in_ready, out_valid, result, result_hi, psr, illegal_op
  );

  modport slave (
    input  in_valid, opcode, a, b, psr_we, psr_wdata,
    output in_ready, out_valid, result, result_hi, psr, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
//==============================================================================
// alu_mul_iter : WIDTH-step shift-add multiplier, signed via magnitude + negate
// Rev 1.0
//==============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int             SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             neg_q, neg_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // One partial-product step: conditional add into the high half, then shift right
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, lo[WIDTH-1:1]};
  endfunction

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    neg_d   = neg_q;
    if (start) begin
      // The first step is folded into the load so the product is ready after WIDTH edges
      mcand_d      = mag(a, signed_mode);
      {hi_d, lo_d} = step({WIDTH{1'b0}}, mag(b, signed_mode), mag(a, signed_mode));
      cnt_d        = '0;
      busy_d       = 1'b1;
      neg_d        = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        {hi_d, lo_d} = step(hi_q, lo_q, mcand_q);
        cnt_d        = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      neg_q   <= neg_d;
    end
  end

  assign done    = busy_q && (cnt_q == LAST);
  assign product = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};

endmodule
`default_nettype wire

// File: rtl/alu_seq_psr.sv
`default_nettype none
//==============================================================================
// alu_seq_psr : registered ALU with valid/ready input, PSR and iterative multiply
// Rev 1.0
//==============================================================================
module alu_seq_psr
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_psr_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  localparam word_t WIDTH_W = word_t'(WIDTH);

  alu_state_t       state_q, state_d;
  word_t            result_q, result_d;
  word_t            result_hi_q, result_hi_d;
  logic [PSR_W-1:0] psr_q, psr_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;
  logic             mul_signed_q, mul_signed_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   addc_sum;
  logic [WIDTH:0]   sub_diff;
  logic [SHW-1:0]   shamt;
  logic             shift_oor;
  word_t            alu_res;
  logic [PSR_W-1:0] alu_flags;
  logic [PSR_W-1:0] mul_flags;
  logic [PSR_W-1:0] op_mask;
  logic [PSR_W-1:0] psr_base;

  // The carry-in reads psr_q, which already holds the carry of the op completed on the previous edge
  assign add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign addc_sum  = add_sum + {{WIDTH{1'b0}}, psr_q[PSR_C]};
  assign sub_diff  = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt     = bus.b[SHW-1:0];
  assign shift_oor = (bus.b >= WIDTH_W);

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (bus.opcode)
      OP_ADD, OP_ADDI: begin
        alu_res          = add_sum[WIDTH-1:0];
        alu_flags[PSR_F] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_ADDU, OP_ADDUI: begin
        alu_res          = add_sum[WIDTH-1:0];
        alu_flags[PSR_C] = add_sum[WIDTH];
      end
      OP_ADDC, OP_ADDCI: begin
        alu_res          = addc_sum[WIDTH-1:0];
        alu_flags[PSR_C] = addc_sum[WIDTH];
      end
      OP_SUB, OP_SUBI: begin
        alu_res          = sub_diff[WIDTH-1:0];
        alu_flags[PSR_C] = sub_diff[WIDTH];
        alu_flags[PSR_F] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOT:  alu_res = ~bus.a;
      OP_TEST: alu_res = bus.a & bus.b;
      OP_LSH:  alu_res = shift_oor ? '0 : (bus.a << shamt);
      OP_RSH:  alu_res = shift_oor ? '0 : (bus.a >> shamt);
      OP_ARSH: alu_res = shift_oor ? {WIDTH{bus.a[WIDTH-1]}}
                                   : $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase

    alu_flags[PSR_N] = alu_res[WIDTH-1];
    alu_flags[PSR_Z] = (alu_res == '0);

    if ((bus.opcode == OP_ADDC) || (bus.opcode == OP_ADDCI)) begin
      alu_flags[PSR_Z] = (alu_res == '0) && !addc_sum[WIDTH];
    end
    if ((bus.opcode == OP_CMP) || (bus.opcode == OP_CMPI)) begin
      alu_flags[PSR_Z] = (bus.a == bus.b);
      alu_flags[PSR_L] = (bus.a < bus.b);
      alu_flags[PSR_N] = ($signed(bus.a) < $signed(bus.b));
    end
  end

  always_comb begin
    mul_flags        = '0;
    mul_flags[PSR_N] = mul_prod[2*WIDTH-1];
    mul_flags[PSR_Z] = (mul_prod == '0);
  end

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    result_hi_d  = result_hi_q;
    out_valid_d  = 1'b0;
    illegal_d    = 1'b0;
    mul_signed_d = mul_signed_q;
    mul_start    = 1'b0;
    op_mask      = '0;
    psr_base     = bus.psr_we ? bus.psr_wdata : psr_q;
    psr_d        = psr_base;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (op_is_mul(bus.opcode)) begin
            state_d      = ST_MUL;
            mul_start    = 1'b1;
            mul_signed_d = (bus.opcode == OP_MUL);
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            illegal_d   = !op_legal(bus.opcode);
            op_mask     = flag_mask(bus.opcode);
            // A flag-writing completion overrides a coincident context restore
            if (op_mask != '0) begin
              psr_d = psr_merge(psr_q, alu_flags, op_mask);
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_prod[WIDTH-1:0];
          result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          op_mask     = mul_signed_q ? flag_mask(OP_MUL) : flag_mask(OP_MULU);
          psr_d       = psr_merge(psr_q, mul_flags, op_mask);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      result_q     <= '0;
      result_hi_q  <= '0;
      psr_q        <= '0;
      out_valid_q  <= 1'b0;
      illegal_q    <= 1'b0;
      mul_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      result_hi_q  <= result_hi_d;
      psr_q        <= psr_d;
      out_valid_q  <= out_valid_d;
      illegal_q    <= illegal_d;
      mul_signed_q <= mul_signed_d;
    end
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (mul_start),
    .signed_mode (bus.opcode == OP_MUL),
    .a           (bus.a),
    .b           (bus.b),
    .done        (mul_done),
    .product     (mul_prod)
  );

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.result_hi  = result_hi_q;
  assign bus.psr        = psr_q;
  assign bus.illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_psr.sv
`default_nettype none
//==============================================================================
// tb_alu_seq_psr : directed self-checking bench for alu_seq_psr (WIDTH = 16)
// Rev 1.0
//==============================================================================
module tb_alu_seq_psr;
  import alu_ops_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_psr_if #(.WIDTH(16)) bus ();

  alu_seq_psr #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.psr_we   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(OP_SUB, 16'h0000, 16'h0001);
    tick();
    idle_in();
    checks++; if (bus.psr !== 5'b10010 || bus.result !== 16'hFFFF) begin errors++;
      $display("FAIL pre_reset: psr=%b result=%h expected psr=10010 result=ffff", bus.psr, bus.result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.in_ready, bus.illegal_op, bus.psr, bus.result, bus.result_hi} !==
                  {1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0000}) begin errors++;
      $display("FAIL reset_outputs: ov=%b rdy=%b ill=%b psr=%b res=%h hi=%h expected 0/1/0/00000/0000/0000",
               bus.out_valid, bus.in_ready, bus.illegal_op, bus.psr, bus.result, bus.result_hi); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_ADDU, 16'hFFFF, 16'h0001);
    tick();
    idle_in();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0000 || bus.psr !== 5'b10001) begin errors++;
      $display("FAIL addu_wrap: ov=%b res=%h psr=%b expected 1/0000/10001", bus.out_valid, bus.result, bus.psr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL ov_pulse: out_valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_carry_chain();
    drive(OP_ADDU, 16'hFFFF, 16'h0002);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0001 || bus.psr !== 5'b10000 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL chain_addu: ov=%b res=%h psr=%b rdy=%b expected 1/0001/10000/1", bus.out_valid, bus.result, bus.psr, bus.in_ready); end
    drive(OP_ADDC, 16'h0001, 16'h0000);
    tick();
    idle_in();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0002 || bus.psr !== 5'b00000) begin errors++;
      $display("FAIL chain_addc: ov=%b res=%h psr=%b expected 1/0002/00000", bus.out_valid, bus.result, bus.psr); end
    tick();
  endtask

  task automatic test_overflow();
    drive(OP_ADD, 16'h7FFF, 16'h0001);
    tick();
    checks++; if (bus.result !== 16'h8000 || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL add_ovf: res=%h psr=%b expected 8000/01010", bus.result, bus.psr); end
    drive(OP_SUB, 16'h8000, 16'h0001);
    tick();
    idle_in();
    checks++; if (bus.result !== 16'h7FFF || bus.psr !== 5'b01000) begin errors++;
      $display("FAIL sub_ovf: res=%h psr=%b expected 7fff/01000", bus.result, bus.psr); end
    tick();
  endtask

  task automatic test_mul();
    int n;
    int ready_bad;
    drive(OP_MUL, 16'hFFFD, 16'h0007);
    tick();
    drive(OP_ADD, 16'h1234, 16'h1111);
    n = 1;
    ready_bad = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (bus.in_ready !== 1'b0) ready_bad++;
      tick();
      n++;
    end
    idle_in();
    checks++; if (n != 17) begin errors++;
      $display("FAIL mul_latency: edges=%0d expected 17", n); end
    checks++; if (ready_bad != 0) begin errors++;
      $display("FAIL mul_ready: in_ready high in %0d busy cycles expected 0", ready_bad); end
    checks++; if (bus.result !== 16'hFFEB || bus.result_hi !== 16'hFFFF || bus.psr !== 5'b01010 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL mul_result: hi=%h lo=%h psr=%b rdy=%b expected ffff/ffeb/01010/1", bus.result_hi, bus.result, bus.psr, bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL mul_ignored_input: out_valid=%b expected 0", bus.out_valid); end

    drive(OP_MULU, 16'hFFFD, 16'h0007);
    tick();
    idle_in();
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 17 || bus.result_hi !== 16'h0006 || bus.result !== 16'hFFEB || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL mulu_result: edges=%0d hi=%h lo=%h psr=%b expected 17/0006/ffeb/01010", n, bus.result_hi, bus.result, bus.psr); end
    tick();
  endtask

  task automatic test_shifts();
    drive(OP_ARSH, 16'h8000, 16'h0014);
    tick();
    checks++; if (bus.result !== 16'hFFFF || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL arsh_oor: res=%h psr=%b expected ffff/01010", bus.result, bus.psr); end
    drive(OP_RSH, 16'h8000, 16'h0010);
    tick();
    checks++; if (bus.result !== 16'h0000 || bus.psr !== 5'b01001) begin errors++;
      $display("FAIL rsh_oor: res=%h psr=%b expected 0000/01001", bus.result, bus.psr); end
    drive(OP_LSH, 16'h0001, 16'h000F);
    tick();
    checks++; if (bus.result !== 16'h8000 || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL lsh_15: res=%h psr=%b expected 8000/01010", bus.result, bus.psr); end
    drive(OP_ARSH, 16'h8000, 16'h0004);
    tick();
    idle_in();
    checks++; if (bus.result !== 16'hF800) begin errors++;
      $display("FAIL arsh_4: res=%h expected f800", bus.result); end
    tick();
  endtask

  task automatic test_edges();
    int ov_seen;
    drive(8'hFF, 16'h0005, 16'h0003);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.illegal_op !== 1'b1 || bus.result !== 16'h0000 || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL illegal: ov=%b ill=%b res=%h psr=%b expected 1/1/0000/01010", bus.out_valid, bus.illegal_op, bus.result, bus.psr); end
    drive(OP_NOP, 16'h0000, 16'h0000);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.illegal_op !== 1'b0 || bus.psr !== 5'b01010) begin errors++;
      $display("FAIL nop: ov=%b ill=%b psr=%b expected 1/0/01010", bus.out_valid, bus.illegal_op, bus.psr); end
    drive(OP_CMP, 16'h0005, 16'h0005);
    bus.psr_we    = 1'b1;
    bus.psr_wdata = 5'b01110;
    tick();
    checks++; if (bus.result !== 16'h0000 || bus.psr !== 5'b01001) begin errors++;
      $display("FAIL cmp_vs_psr_we: res=%h psr=%b expected 0000/01001", bus.result, bus.psr); end
    bus.in_valid  = 1'b0;
    bus.psr_wdata = 5'b10110;
    tick();
    idle_in();
    checks++; if (bus.psr !== 5'b10110 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL psr_restore: psr=%b ov=%b expected 10110/0", bus.psr, bus.out_valid); end
    drive(OP_CMP, 16'h0001, 16'hFFFF);
    tick();
    idle_in();
    checks++; if (bus.psr !== 5'b10100) begin errors++;
      $display("FAIL cmp_lt: psr=%b expected 10100", bus.psr); end

    drive(OP_MUL, 16'h0003, 16'h0003);
    tick();
    idle_in();
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.in_ready, bus.psr, bus.result} !== {1'b0, 1'b1, 5'b00000, 16'h0000}) begin errors++;
      $display("FAIL mul_reset: ov=%b rdy=%b psr=%b res=%h expected 0/1/00000/0000", bus.out_valid, bus.in_ready, bus.psr, bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid === 1'b1) ov_seen++;
    end
    checks++; if (ov_seen != 0) begin errors++;
      $display("FAIL mul_abort: out_valid seen %0d times expected 0", ov_seen); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 8'h00;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.psr_we    = 1'b0;
    bus.psr_wdata = 5'b00000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    test_reset();
    test_carry_chain();
    test_overflow();
    test_mul();
    test_shifts();
    test_edges();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
